hyperram_request_queue: RTL and testbench
=========================================

# hyperram_request_queue

Upstream front-end for the `hyperram` controller. It accepts CPU memory requests through a valid/ready handshake and buffers them in an in-order FIFO. Each request is issued to the controller as a single `transaction_begin` pulse, with address, data and mask held stable for the whole transaction. Read data is returned as a one-cycle response pulse. Writes are posted: they are acknowledged at enqueue and produce no response.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of 2, ≥2.
- `BUSY_TIMEOUT`, 15: maximum cycles in WAIT_BUSY before the request is abandoned.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_address`  in  32  byte address, passed through unchanged.
- `req_write_data`  in  32  write data.
- `req_write_enable`  in  1  1=write, 0=read.
- `req_write_mask`  in  4  per-byte mask, passed through to the controller.
- `rsp_valid`  out  1  one-cycle pulse; read data valid.
- `rsp_data`  out  32  read data; held until the next response.
- `address`  out  32  to controller.
- `data_out`  out  32  to controller.
- `write_enable`  out  1  to controller.
- `write_mask`  out  4  to controller.
- `transaction_begin`  out  1  to controller; one-cycle pulse.
- `transaction_end`  in  1  from controller; high while the controller is idle.
- `data_in`  in  32  from controller; read result.
- `queue_level`  out  $clog2(DEPTH)+1  entries currently queued, 0..DEPTH.
- `busy`  out  1  FSM not in IDLE, or queue non-empty.
- `timeout_error`  out  1  sticky; set on a BUSY_TIMEOUT expiry.

## Operation

- Push occurs when `req_valid && req_ready`. The entry is {address, write_data, write_enable, write_mask}.
- The FIFO uses wrapping read/write pointers and an occupancy counter. `full` = level==DEPTH; `empty` = level==0.
- Push and pop in the same cycle leave the level unchanged.
- The head register drives the controller outputs. It loads only on pop and holds otherwise.
- FSM states:
  - IDLE: if `!empty && transaction_end`, pop into the head register and go to ISSUE.
  - ISSUE: `transaction_begin`=1 for this cycle only; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `transaction_end`==0, go to WAIT_DONE.
    - Otherwise increment the counter. When counter==BUSY_TIMEOUT, set `timeout_error`, go to IDLE, and drop the request. A dropped read produces no response.
  - WAIT_DONE: when `transaction_end`==1:
    - Read: capture `data_in` into `rsp_data` and go to RESPOND.
    - Write: go to IDLE.
  - RESPOND: `rsp_valid`=1 for this cycle; go to IDLE.
- Requests are issued strictly in order. Read-after-write ordering follows from the FIFO, and there is no bypass.
- `timeout_error` clears only on `rst`.

## Timing

- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - `address`, `data_out`, `write_enable`, `write_mask` = 0.
  - `transaction_begin`=0, `queue_level`=0, `busy`=0, `timeout_error`=0.
  - FSM in IDLE; pointers at 0.
- `req_ready` is registered-state based. When full, it stays low even in a cycle that pops; it rises the following cycle.
- Push to visibility: an entry pushed in cycle N is eligible for pop in cycle N+1 (IDLE sees `!empty`).
- Pop to begin: pop in cycle P; controller outputs valid from P+1; `transaction_begin` high in P+1 only.
- Controller outputs are stable from P+1 until the next pop, and always at least until `transaction_end` returns high.
- Read latency: `rsp_valid` is asserted 1 cycle after `transaction_end` is seen high in WAIT_DONE.
- Minimum spacing between consecutive `transaction_begin` pulses: 4 cycles (ISSUE, ≥1 WAIT_BUSY, ≥1 WAIT_DONE, IDLE pop).
- Reset mid-transaction: FSM returns to IDLE, the queue is emptied, no response is emitted, and `transaction_begin` is 0 in the cycle after reset. A controller still mid-transaction completes on its own. The queue issues nothing new until it sees `transaction_end`=1.

## Test plan

- Single read: push read at 0x00000040 with a controller model returning 0xCAFEF00D → exactly one `transaction_begin` pulse, `write_enable`=0, `rsp_valid` pulse with `rsp_data`=0xCAFEF00D, `queue_level` back to 0.
- Posted write: push write at 0x10 with data 0x12345678 and mask 0xF → `req_ready` stays 1, `data_out`=0x12345678 is held through the transaction, no `rsp_valid`.
- Fill/backpressure: with the controller stalled busy, push DEPTH+2 requests → `req_ready` falls at level 4, the 5th request is held; after one pop, `req_ready` rises the next cycle.
- Ordering: queue write 0xAAAA5555 at A, then read A, using a memory-backed model → the read returns 0xAAAA5555.
- Timeout: `transaction_end` stuck at 1 after begin → after 15 cycles `timeout_error`=1, FSM in IDLE, the next queued request is issued.
- Reset mid-operation: assert `rst` in WAIT_DONE with 3 entries queued → `queue_level`=0, `rsp_valid` never pulses, all outputs at reset values.

Source files
------------

// File: rtl/hyperram_request_queue.sv
// hyperram_request_queue: in-order request FIFO and transaction sequencer for the hyperram controller
module hyperram_request_queue #(
  parameter int DEPTH = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_address,
  input  logic [31:0]               req_write_data,
  input  logic                      req_write_enable,
  input  logic [3:0]                req_write_mask,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [31:0]               address,
  output logic [31:0]               data_out,
  output logic                      write_enable,
  output logic [3:0]                write_mask,
  output logic                      transaction_begin,
  input  logic                      transaction_end,
  input  logic [31:0]               data_in,
  output logic [$clog2(DEPTH):0]    queue_level,
  output logic                      busy,
  output logic                      timeout_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;
  state_t state, state_nx;
  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic        fifo_we   [DEPTH];
  logic [3:0]  fifo_mask [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic full, empty, push, pop, expire;
  assign full = queue_level == LW'(DEPTH);
  assign empty = queue_level == '0;
  assign req_ready = !full;
  assign push = req_valid && req_ready;
  assign pop = state == IDLE && !empty && transaction_end;
  assign expire = state == WAIT_BUSY && transaction_end && cnt == CW'(BUSY_TIMEOUT - 1);
  assign transaction_begin = state == ISSUE;
  assign rsp_valid = state == RESPOND;
  assign busy = state != IDLE || !empty;
  // Entry storage; pointers and level decide which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_address;
      fifo_data[wr_ptr] <= req_write_data;
      fifo_we[wr_ptr]   <= req_write_enable;
      fifo_mask[wr_ptr] <= req_write_mask;
    end
  end
  // Wrapping pointers and occupancy; push+pop together keeps the level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      queue_level <= queue_level + LW'(push) - LW'(pop);
    end
  end
  // Head register feeds the controller and only changes on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      address <= '0;
      data_out <= '0;
      write_enable <= 1'b0;
      write_mask <= '0;
    end else if (pop) begin
      address <= fifo_addr[rd_ptr];
      data_out <= fifo_data[rd_ptr];
      write_enable <= fifo_we[rd_ptr];
      write_mask <= fifo_mask[rd_ptr];
    end
  end
  // Busy-wait counter, read data capture and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rsp_data <= '0;
      timeout_error <= 1'b0;
    end else begin
      cnt <= state == ISSUE ? '0 : (state == WAIT_BUSY && transaction_end) ? cnt + 1'b1 : cnt;
      if (state == WAIT_DONE && transaction_end && !write_enable) rsp_data <= data_in;
      if (expire) timeout_error <= 1'b1;
    end
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // Next-state: issue, wait for controller to go busy, wait for it to finish, respond on reads
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = pop ? ISSUE : IDLE;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = !transaction_end ? WAIT_DONE : expire ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_nx = !transaction_end ? WAIT_DONE : write_enable ? IDLE : RESPOND;
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hyperram_request_queue.sv
// tb_hyperram_request_queue: scoreboard bench with memory-backed controller model
module tb_hyperram_request_queue;
  localparam int DEPTH = 4;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic w; logic [3:0] m;} req_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [31:0] req_address = 0, req_write_data = 0;
  logic req_write_enable = 0;
  logic [3:0] req_write_mask = 0;
  logic rsp_valid;
  logic [31:0] rsp_data, address, data_out, data_in = 0;
  logic write_enable, transaction_begin, transaction_end = 1, busy, timeout_error;
  logic [3:0] write_mask;
  logic [$clog2(DEPTH):0] queue_level;
  int checks = 0, errors = 0, begin_count = 0;
  longint cyc = 0, last_begin = -100;
  bit stall = 0, stuck_once = 0, hold_once = 0, release_hold = 0, ctl_active = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ctl_mem [logic [31:0]];
  req_t issue_q[$];
  logic [31:0] rsp_q[$];

  hyperram_request_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_write_data(req_write_data),
    .req_write_enable(req_write_enable), .req_write_mask(req_write_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .address(address), .data_out(data_out),
    .write_enable(write_enable), .write_mask(write_mask), .transaction_begin(transaction_begin),
    .transaction_end(transaction_end), .data_in(data_in), .queue_level(queue_level),
    .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model: memory as the CPU sees it, in request order
  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m, input bit drop);
    logic [31:0] cur = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    issue_q.push_back('{a: a, d: d, w: w, m: m});
    if (w) ref_mem[a] = merge(cur, d, m);
    else if (!drop) rsp_q.push_back(cur);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m, input bit drop);
    int n = 0;
    req_valid = 1; req_address = a; req_write_data = d; req_write_enable = w; req_write_mask = m;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) chk("push_wait", {31'b0, req_ready}, 1);
    else model_push(a, d, w, m, drop);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while ((busy || ctl_active || rsp_q.size() != 0) && n < 1000);
    chk("idle_reached", 32'(n < 1000), 1);
  endtask

  task automatic check_reset_values();
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_rsp", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ctl", {26'b0, write_enable, write_mask, transaction_begin}, 0);
    chk("rst_level", 32'(queue_level), 0);
    chk("rst_flags", {30'b0, busy, timeout_error}, 0);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_data, 32'hxxxxxxxx);
      else chk("rsp_data", rsp_data, rsp_q.pop_front());
    end
  end

  // Controller model: checks issue order and spacing, goes busy, completes against its own memory
  initial begin
    forever begin
      @(negedge clk);
      if (transaction_begin) begin
        req_t e;
        logic [31:0] ca, cd;
        logic cw;
        logic [3:0] cm;
        begin_count++;
        chk("begin_spacing", 32'(cyc - last_begin >= 4), 1);
        last_begin = cyc;
        if (issue_q.size() == 0) chk("issue_unexpected", address, 32'hxxxxxxxx);
        else begin
          e = issue_q.pop_front();
          chk("issue_addr", address, e.a);
          chk("issue_data", data_out, e.d);
          chk("issue_ctl", {27'b0, write_enable, write_mask}, {27'b0, e.w, e.m});
        end
        ca = address; cd = data_out; cw = write_enable; cm = write_mask;
        if (stuck_once) stuck_once = 0;
        else if (hold_once) begin
          int n = 0;
          hold_once = 0;
          ctl_active = 1;
          @(negedge clk);
          transaction_end = 0;
          while (!release_hold && n < 3000) begin @(negedge clk); n++; end
          chk("hold_released", {31'b0, release_hold}, 1);
          transaction_end = 1;
          ctl_active = 0;
        end else begin
          ctl_active = 1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          transaction_end = 0;
          repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            chk("hold_addr", address, ca);
            chk("hold_data", data_out, cd);
            chk("hold_ctl", {27'b0, write_enable, write_mask}, {27'b0, cw, cm});
          end
          if (cw) ctl_mem[ca] = merge(ctl_mem.exists(ca) ? ctl_mem[ca] : init_val(ca), cd, cm);
          else data_in = ctl_mem.exists(ca) ? ctl_mem[ca] : init_val(ca);
          transaction_end = 1;
          ctl_active = 0;
        end
      end else transaction_end = !stall;
    end
  end

  initial begin
    int bc;
    cycles(3);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    // Single read
    ref_mem[32'h40] = 32'hCAFEF00D;
    ctl_mem[32'h40] = 32'hCAFEF00D;
    bc = begin_count;
    push_req(32'h40, 32'h0, 0, 4'h0, 0);
    wait_idle();
    chk("single_begins", begin_count - bc, 1);
    chk("single_level", 32'(queue_level), 0);
    chk("single_rsp_data", rsp_data, 32'hCAFEF00D);
    // Posted write
    push_req(32'h10, 32'h12345678, 1, 4'hF, 0);
    chk("write_ready", {31'b0, req_ready}, 1);
    wait_idle();
    chk("write_mem", ctl_mem[32'h10], 32'h12345678);
    // Ordering: write then read of the same address
    push_req(32'h80, 32'hAAAA5555, 1, 4'hF, 0);
    push_req(32'h80, 32'h0, 0, 4'h0, 0);
    wait_idle();
    chk("order_rsp_data", rsp_data, 32'hAAAA5555);
    // Randomized traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      push_req({27'b0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
      cycles($urandom_range(0, 2));
    end
    wait_idle();
    // Fill with the controller held busy
    stall = 1;
    cycles(2);
    for (int i = 0; i < DEPTH; i++) push_req({27'b0, 3'(i), 2'b00}, $urandom, 1'(i % 2), 4'hF, 0);
    @(negedge clk);
    chk("fill_level", 32'(queue_level), DEPTH);
    chk("fill_ready", {31'b0, req_ready}, 0);
    req_valid = 1; req_address = 32'h14; req_write_data = 32'h0; req_write_enable = 0; req_write_mask = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", {31'b0, req_ready}, 0);
      chk("full_level", 32'(queue_level), DEPTH);
    end
    @(posedge clk); #1;
    stall = 0;
    @(negedge clk); #1;
    chk("pop_cycle_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    chk("after_pop_ready", {31'b0, req_ready}, 1);
    chk("after_pop_level", 32'(queue_level), DEPTH - 1);
    model_push(32'h14, 32'h0, 0, 4'h0, 0);
    @(posedge clk); #1;
    req_valid = 0;
    push_req(32'h18, 32'h0, 0, 4'h0, 0);
    wait_idle();
    // Timeout: controller never goes busy for one read, which is dropped
    stuck_once = 1;
    push_req(32'h100, $urandom, 0, 4'h0, 1);
    push_req(32'h104, $urandom, 0, 4'h0, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!transaction_begin && n < 50) begin @(negedge clk); n++; end
      chk("to_begin_seen", {31'b0, transaction_begin}, 1);
    end
    repeat (14) @(negedge clk);
    chk("to_not_early", {31'b0, timeout_error}, 0);
    repeat (3) @(negedge clk);
    chk("to_set", {31'b0, timeout_error}, 1);
    wait_idle();
    chk("to_sticky", {31'b0, timeout_error}, 1);
    // Reset while waiting for a read to complete, with three entries queued
    hold_once = 1;
    push_req(32'h44, 32'h0, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) push_req(32'h48 + 32'(4 * i), 32'h0, 0, 4'h0, 0);
    cycles(3);
    @(negedge clk);
    chk("pre_rst_level", 32'(queue_level), 3);
    @(posedge clk); #1;
    rst = 1;
    issue_q.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    bc = begin_count;
    push_req(32'h60, 32'h0, 0, 4'h0, 0);
    cycles(4);
    chk("held_level", 32'(queue_level), 1);
    chk("held_no_begin", begin_count - bc, 0);
    release_hold = 1;
    wait_idle();
    chk("post_rst_begins", begin_count - bc, 1);
    chk("issue_q_drained", issue_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
